// File: rtl/led_share_arbiter.sv
// Round-robin arbiter that lends one 8-bit LED bank to four requesters.
// A winner owns the bank for HOLD_CYCLES cycles (or until it drops its
// request), its pattern is captured once at the grant edge, and a one-cycle
// done pulse marks a window that ran to completion.
module led_share_arbiter #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [31:0] data_in,
  output logic [3:0]  grant,
  output logic [3:0]  done,
  output logic [7:0]  led,
  output logic        busy
);

  typedef enum logic {IDLE = 1'b0, SHOW = 1'b1} state_t;

  state_t           state, state_nx;
  logic [1:0]       ptr, ptr_nx;
  logic [1:0]       win, win_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [3:0]       grant_nx, done_nx;
  logic [7:0]       led_nx;
  logic [1:0]       pick, idx;
  logic             found;

  // Round-robin scan: first active request at ptr, ptr+1, ... (mod 4)
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    idx   = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Next-state and registered-output logic; abort is tested before completion
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    win_nx   = win;
    cnt_nx   = cnt;
    grant_nx = grant;
    done_nx  = 4'b0000;
    led_nx   = led;
    case (state)
      IDLE: begin
        grant_nx = 4'b0000;
        if (found) begin
          state_nx = SHOW;
          win_nx   = pick;
          grant_nx = 4'b0001 << pick;
          led_nx   = data_in[{pick, 3'b000} +: 8];
          cnt_nx   = CNT_W'(HOLD_CYCLES - 1);
        end
      end
      SHOW: begin
        if (!req[win]) begin
          state_nx = IDLE;
          grant_nx = 4'b0000;
          ptr_nx   = win + 2'd1;
        end else if (cnt == '0) begin
          state_nx = IDLE;
          grant_nx = 4'b0000;
          done_nx  = 4'b0001 << win;
          ptr_nx   = win + 2'd1;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = 4'b0000;
      end
    endcase
  end

  // State and output registers, cleared immediately by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 2'd0;
      win   <= 2'd0;
      cnt   <= '0;
      grant <= 4'b0000;
      done  <= 4'b0000;
      led   <= 8'h00;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      win   <= win_nx;
      cnt   <= cnt_nx;
      grant <= grant_nx;
      done  <= done_nx;
      led   <= led_nx;
    end
  end

  assign busy = (state == SHOW);

endmodule

// File: tb/tb_led_share_arbiter.sv
// Directed bench for led_share_arbiter: HOLD_CYCLES=4 and HOLD_CYCLES=1 builds.
// Inputs change and outputs are sampled on the falling clock edge.
`timescale 1ns/100ps
module tb_led_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = 4'b0000, req1 = 4'b0000;
  logic [31:0] data = 32'h0, data1 = 32'h0;
  logic [3:0]  grant, done, grant1, done1;
  logic [7:0]  led, led1;
  logic        busy, busy1;
  int checks = 0;
  int failures = 0;

  led_share_arbiter #(.HOLD_CYCLES(4), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .req(req), .data_in(data),
    .grant(grant), .done(done), .led(led), .busy(busy));

  led_share_arbiter #(.HOLD_CYCLES(1), .CNT_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .data_in(data1),
    .grant(grant1), .done(done1), .led(led1), .busy(busy1));

  always #1 clk = ~clk;

  // Short reset pulse between edges; next rising edge may arbitrate
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #0.5 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req = 4'b1111; data = 32'h44332211;
    @(negedge clk);
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    checks++; if (done  !== 4'b0000) begin failures++; $display("FAIL reset_done got=%b exp=0000", done); end
    checks++; if (led   !== 8'h00)   begin failures++; $display("FAIL reset_led got=%h exp=00", led); end
    checks++; if (busy  !== 1'b0)    begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    req = 4'b0000;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [3:0] eg, ed;
    req = 4'b0010; data = 32'h0000_A500;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      eg = (c < 4) ? 4'b0010 : 4'b0000;
      ed = (c == 4) ? 4'b0010 : 4'b0000;
      checks++; if (grant !== eg) begin failures++; $display("FAIL single_grant c=%0d got=%b exp=%b", c, grant, eg); end
      checks++; if (done !== ed) begin failures++; $display("FAIL single_done c=%0d got=%b exp=%b", c, done, ed); end
      checks++; if (led !== 8'hA5) begin failures++; $display("FAIL single_led c=%0d got=%h exp=a5", c, led); end
      checks++; if (busy !== (c < 4)) begin failures++; $display("FAIL single_busy c=%0d got=%b exp=%b", c, busy, (c < 4)); end
      if (c == 4) req = 4'b0000;
    end
  endtask

  task automatic test_all_request();
    logic [3:0] eg, ed;
    logic [7:0] el;
    logic [7:0] pat [4];
    int p, r;
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
    do_reset();
    req = 4'b1111; data = 32'h44332211;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      p = (c / 5) % 4; r = c % 5;
      eg = (r < 4)  ? (4'b0001 << p) : 4'b0000;
      ed = (r == 4) ? (4'b0001 << p) : 4'b0000;
      el = pat[p];
      checks++; if (grant !== eg) begin failures++; $display("FAIL all_grant c=%0d got=%b exp=%b", c, grant, eg); end
      checks++; if (done !== ed) begin failures++; $display("FAIL all_done c=%0d got=%b exp=%b", c, done, ed); end
      checks++; if (led !== el) begin failures++; $display("FAIL all_led c=%0d got=%h exp=%h", c, led, el); end
    end
    req = 4'b0000;
  endtask

  task automatic test_abort();
    do_reset();
    req = 4'b0001; data = 32'h0000_5A07;
    @(negedge clk); // first SHOW cycle
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL abort_grant0 got=%b exp=0001", grant); end
    @(negedge clk); // second SHOW cycle: drop req[0], request 1 pending
    req = 4'b0010;
    @(negedge clk); // IDLE after abort; raise req[0] too so the pick shows ptr=1
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL abort_clear got=%b exp=0000", grant); end
    checks++; if (done !== 4'b0000) begin failures++; $display("FAIL abort_done got=%b exp=0000", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    req = 4'b0011;
    @(negedge clk);
    checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL abort_next_grant got=%b exp=0010", grant); end
    checks++; if (led !== 8'h5A) begin failures++; $display("FAIL abort_next_led got=%h exp=5a", led); end
    checks++; if (done !== 4'b0000) begin failures++; $display("FAIL abort_done2 got=%b exp=0000", done); end
    req = 4'b0000; // abort requester 1 as well
    @(negedge clk);
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL abort2_clear got=%b exp=0000", grant); end
    checks++; if (done !== 4'b0000) begin failures++; $display("FAIL abort2_done got=%b exp=0000", done); end
  endtask

  task automatic test_data_change();
    logic [3:0] ed;
    req = 4'b0100; data = 32'h003C_0000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      ed = (c == 4) ? 4'b0100 : 4'b0000;
      checks++; if (led !== 8'h3C) begin failures++; $display("FAIL data_led c=%0d got=%h exp=3c", c, led); end
      checks++; if (done !== ed) begin failures++; $display("FAIL data_done c=%0d got=%b exp=%b", c, done, ed); end
      if (c == 1) data = 32'h00FF_0000;
      if (c == 4) req = 4'b0000;
    end
  endtask

  task automatic test_async_reset();
    req = 4'b0001; data = 32'h0000_0099;
    @(negedge clk);
    checks++; if (grant !== 4'b0001 || led !== 8'h99) begin failures++; $display("FAIL areset_pre grant=%b led=%h exp=0001/99", grant, led); end
    #0.4 rst_n = 1'b0;
    #0.2;
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL areset_grant got=%b exp=0000", grant); end
    checks++; if (done !== 4'b0000) begin failures++; $display("FAIL areset_done got=%b exp=0000", done); end
    checks++; if (led !== 8'h00) begin failures++; $display("FAIL areset_led got=%h exp=00", led); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL areset_busy got=%b exp=0", busy); end
    req = 4'b1000; data = 32'hE700_0000;
    @(negedge clk); // an edge passes with reset held: still idle
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL areset_held got=%b exp=0000", grant); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (grant !== 4'b1000) begin failures++; $display("FAIL areset_owner got=%b exp=1000", grant); end
    checks++; if (led !== 8'hE7) begin failures++; $display("FAIL areset_led2 got=%h exp=e7", led); end
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_hold1();
    logic [3:0] eg, ed;
    logic [7:0] el;
    do_reset();
    req1 = 4'b0101; data1 = 32'h0004_0001;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      case (c % 4)
        0: begin eg = 4'b0001; ed = 4'b0000; el = 8'h01; end
        1: begin eg = 4'b0000; ed = 4'b0001; el = 8'h01; end
        2: begin eg = 4'b0100; ed = 4'b0000; el = 8'h04; end
        default: begin eg = 4'b0000; ed = 4'b0100; el = 8'h04; end
      endcase
      checks++; if (grant1 !== eg) begin failures++; $display("FAIL hold1_grant c=%0d got=%b exp=%b", c, grant1, eg); end
      checks++; if (done1 !== ed) begin failures++; $display("FAIL hold1_done c=%0d got=%b exp=%b", c, done1, ed); end
      checks++; if (led1 !== el) begin failures++; $display("FAIL hold1_led c=%0d got=%h exp=%h", c, led1, el); end
    end
    req1 = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_request();
    test_abort();
    test_data_change();
    test_async_reset();
    test_hold1();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
